// File: rtl/imem_fetch_unit.sv
// rtl/imem_fetch_unit.sv - instruction memory with valid/ready fetch port, 2-deep response buffer and load port
module imem_fetch_unit #(
    parameter  int DATA_W = 32,
    parameter  int ADDR_W = 32,
    parameter  int DEPTH  = 64,
    localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_req_valid,
    input  logic [ADDR_W-1:0] i_req_addr,
    output logic              o_req_ready,
    output logic              o_resp_valid,
    output logic [DATA_W-1:0] o_resp_data,
    output logic [1:0]        o_resp_fault,
    input  logic              i_resp_ready,
    input  logic              i_flush,
    input  logic              i_ld_en,
    input  logic [IDX_W-1:0]  i_ld_index,
    input  logic [DATA_W-1:0] i_ld_data
);

    localparam int BYTES = DATA_W / 8;
    localparam int OFF_W = $clog2(BYTES);

    // Instruction storage; never reset, only written through the load port.
    logic [DATA_W-1:0] r_mem [DEPTH];

    // Response buffer: two slots addressed by a head pointer and an occupancy count.
    logic [DATA_W-1:0] r_fifo_data  [2];
    logic [1:0]        r_fifo_fault [2];
    logic              r_head;
    logic [1:0]        r_count;

    logic [ADDR_W-1:0] w_word_index;
    logic              w_misaligned;
    logic              w_out_of_range;
    logic [1:0]        w_push_fault;
    logic [DATA_W-1:0] w_push_data;
    logic              w_push;
    logic              w_pop;
    logic              w_tail;
    logic              w_ld_in_range;

    // Byte address to word index; range check uses the full address width so high bits never alias.
    assign w_word_index   = i_req_addr >> OFF_W;
    assign w_misaligned   = (i_req_addr & ADDR_W'(BYTES - 1)) != '0;
    assign w_out_of_range = w_word_index >= ADDR_W'(DEPTH);
    assign w_push_fault   = {w_out_of_range, w_misaligned};

    // Faulted fetches return all ones rather than whatever the truncated index would hit.
    assign w_push_data = (w_push_fault != 2'b00) ? '1 : r_mem[w_word_index[IDX_W-1:0]];

    // Acceptance depends only on local state, never on the consumer's ready.
    assign o_req_ready = !i_reset && !i_flush && (r_count < 2'd2);
    assign w_push      = i_req_valid && o_req_ready;
    assign w_pop       = o_resp_valid && i_resp_ready;

    // With one entry held, the free slot is the one opposite the head.
    assign w_tail = r_head ^ r_count[0];

    // Load indices beyond DEPTH only exist when DEPTH is not a power of two.
    generate
        if ((2 ** IDX_W) > DEPTH) begin : g_ld_check
            assign w_ld_in_range = i_ld_index < IDX_W'(DEPTH);
        end else begin : g_ld_full
            assign w_ld_in_range = 1'b1;
        end
    endgenerate

    // Head data is shown only while valid; otherwise the bus idles at all ones / no fault.
    assign o_resp_valid = (r_count != 2'd0);
    assign o_resp_data  = o_resp_valid ? r_fifo_data[r_head]  : '1;
    assign o_resp_fault = o_resp_valid ? r_fifo_fault[r_head] : 2'b00;

    // Program load: write happens at the edge, so a same-cycle fetch captured the old word.
    always_ff @(posedge i_clk) begin
        if (i_ld_en && w_ld_in_range) begin
            r_mem[i_ld_index] <= i_ld_data;
        end
    end

    // Payload slots need no reset; the count alone decides what is visible.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_fifo_data[w_tail]  <= w_push_data;
            r_fifo_fault[w_tail] <= w_push_fault;
        end
    end

    // Occupancy and head pointer; flush empties the buffer and drops any same-cycle pop.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_count <= 2'd0;
            r_head  <= 1'b0;
        end else if (i_flush) begin
            r_count <= 2'd0;
            r_head  <= 1'b0;
        end else begin
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01: begin
                    r_count <= r_count - 2'd1;
                    r_head  <= ~r_head;
                end
                2'b11:   r_head  <= ~r_head;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
